writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Writeback stage sitting directly upstream of the integer register file; it produces the file's `wr_en`/`wr_addr`/`wr_data` write port.
- Arbitrates between two result sources (ALU path, load path) using valid/ready handshakes, with an anti-starvation counter.
- Suppresses x0 writes.
- Maintains a pending-load scoreboard so decode can stall on operands whose load result has not yet reached the register file.

Parameters:
- XLEN, 32: data width.
- REG_FILE_DEPTH, 32: number of architectural registers.
- REG_FILE_ADDR_LEN, $clog2(REG_FILE_DEPTH): register index width.
- STARVE_LIMIT, 4: consecutive cycles a held load may lose arbitration before it is forced through (range 1..15).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  REG_FILE_ADDR_LEN  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load result valid.
- ld_ready  out  1  load holding register empty.
- ld_rd  in  REG_FILE_ADDR_LEN  load destination register.
- ld_data  in  XLEN  load result.
- ld_issue  in  1  decode issued a load this cycle.
- ld_issue_rd  in  REG_FILE_ADDR_LEN  destination of the issued load.
- wr_en  out  1  register file write enable (registered).
- wr_addr  out  REG_FILE_ADDR_LEN  register file write address (registered).
- wr_data  out  XLEN  register file write data (registered).
- pending  out  REG_FILE_DEPTH  scoreboard; bit i = load to xi outstanding (registered).
- protocol_err  out  1  sticky; set on an illegal issue.

Behaviour:
- Reset (reset==0 at an edge):
  - wr_en=0, wr_addr=0, wr_data=0, pending=0, protocol_err=0.
  - Holding register empties; starve counter=0.
  - Any in-flight result is discarded.
  - Combinational outputs follow the cleared state.
- Load holding register (hold_valid, hold_rd, hold_data):
  - ld_ready = !hold_valid, combinational.
  - A transfer occurs when ld_valid && ld_ready; the result is captured at that edge.
  - A load never goes straight to the write port; it always spends at least one cycle in hold.
- Arbitration each cycle between the ALU and hold:
  - Only alu_valid: alu_ready=1; the ALU result is selected.
  - Only hold_valid: hold is selected and empties at the edge.
  - Both, starve < STARVE_LIMIT: ALU wins, alu_ready=1, starve increments.
  - Both, starve == STARVE_LIMIT: hold wins, alu_ready=0, starve resets to 0.
  - starve resets to 0 whenever hold drains.
  - alu_ready is combinational from alu_valid, hold_valid and starve. It does not depend on ld_valid.
- Hold refill: if hold drains at an edge, ld_ready is still 0 that cycle, so a new load is accepted in the following cycle. This gives at most one load per 2 cycles.
- Write port:
  - The selected result is registered onto wr_addr/wr_data at the edge, with wr_en=1 unless rd==0.
  - Latency: accepted at cycle N, wr_en high in cycle N+1; the register file commits at the N+1→N+2 edge.
  - With no selection, or rd==0, wr_en=0 next cycle; wr_addr/wr_data hold their previous values.
  - A registered flag wr_is_load accompanies each write.
- Scoreboard:
  - Set: ld_issue && ld_issue_rd!=0 sets pending[ld_issue_rd] at the edge.
  - Clear: wr_en && wr_is_load clears pending[wr_addr] at the edge. This is the edge where the register file commits, so decode never sees pending=0 with stale data.
  - Same register set and cleared in the same cycle: set wins.
  - ld_issue to x0 is ignored.
  - ld_issue to an already-pending register: the bit stays set and protocol_err is set, sticky until reset.
  - pending[0] is always 0.
- Out of scope: no ordering between ALU and load results to the same register. Decode guarantees this via pending (WAW stall).

Decomposition:
- Shared package `rv32_pkg`: XLEN, REG_FILE_DEPTH, REG_FILE_ADDR_LEN, X0 index constant, and a writeback-entry struct {rd, data, is_load}.
- One natural sub-module: `wb_scoreboard` (pending vector plus protocol_err, set/clear ports). Arbitration and holding logic stay in the top module.

Test Plan:
- Reset mid-traffic: hold full, pending=0x0000_0020, reset low for one edge → wr_en=0, pending=0, ld_ready=1, protocol_err=0 next cycle.
- ALU only: alu_valid with rd=5, data=0xDEADBEEF at cycle N → alu_ready=1; wr_en=1, wr_addr=5, wr_data=0xDEADBEEF in cycle N+1; rd=0 variant → wr_en=0.
- Load plus scoreboard:
  - ld_issue rd=7 → pending[7]=1.
  - Load result rd=7, data=0x12345678 → captured in hold, written in a later cycle.
  - pending[7] clears at the edge ending that wr_en cycle.
- Starvation, STARVE_LIMIT=4: hold valid plus continuous alu_valid → ALU wins 4 cycles; 5th cycle alu_ready=0, the load writes; ALU wins the following cycle.
- Simultaneous set and clear of x9: the load write to x9 retires in the same cycle as ld_issue rd=9 → pending[9] stays 1, protocol_err stays 0.
- Protocol error: ld_issue rd=3 twice without retirement → protocol_err=1 and stays 1; ld_issue rd=0 → pending unchanged.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 writeback definitions: data/register widths and the writeback entry carried
// through the load holding register and the register-file write port.
package rv32_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned REG_FILE_DEPTH    = 32;
  localparam int unsigned REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH);

  localparam logic [REG_FILE_ADDR_LEN-1:0] X0 = '0;

  typedef struct packed {
    logic [REG_FILE_ADDR_LEN-1:0] rd;
    logic [XLEN-1:0]              data;
    logic                         is_load;
  } wb_entry_t;

  // x0 is hardwired to zero, so a result aimed at it never reaches the register file.
  function automatic logic writes_reg(input logic [REG_FILE_ADDR_LEN-1:0] rd);
    return rd != X0;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, set on load issue and
// cleared when the load result commits; flags a second issue to a still-pending register.
module wb_scoreboard #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_LEN = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [ADDR_LEN-1:0] set_idx,
  input  logic                clr_en,
  input  logic [ADDR_LEN-1:0] clr_idx,
  output logic [DEPTH-1:0]    pending,
  output logic                protocol_err
);

  logic [DEPTH-1:0] pending_q, pending_d;
  logic             err_q, err_d;
  logic             set_live;
  logic             clr_hits_set;

  always_comb begin
    set_live     = set_en && (set_idx != '0);
    clr_hits_set = clr_en && (clr_idx == set_idx);

    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_idx] = 1'b0;
    end
    // Applied after the clear so a same-cycle set of the retiring register wins.
    if (set_live) begin
      pending_d[set_idx] = 1'b1;
    end
    pending_d[0] = 1'b0;

    // Re-issuing a register whose load retires this very edge is legal.
    err_d = err_q | (set_live && pending_q[set_idx] && !clr_hits_set);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign pending      = pending_q;
  assign protocol_err = err_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU results against a one-entry load holding register with an
// anti-starvation counter, drives the registered register-file write port and the scoreboard.
module writeback_unit #(
  parameter int unsigned XLEN              = rv32_pkg::XLEN,
  parameter int unsigned REG_FILE_DEPTH    = rv32_pkg::REG_FILE_DEPTH,
  parameter int unsigned REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH),
  parameter int unsigned STARVE_LIMIT      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REG_FILE_ADDR_LEN-1:0] alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [REG_FILE_ADDR_LEN-1:0] ld_rd,
  input  logic [XLEN-1:0]              ld_data,
  input  logic                         ld_issue,
  input  logic [REG_FILE_ADDR_LEN-1:0] ld_issue_rd,
  output logic                         wr_en,
  output logic [REG_FILE_ADDR_LEN-1:0] wr_addr,
  output logic [XLEN-1:0]              wr_data,
  output logic [REG_FILE_DEPTH-1:0]    pending,
  output logic                         protocol_err
);

  import rv32_pkg::*;

  logic      hold_valid_q, hold_valid_d;
  wb_entry_t hold_q, hold_d;
  logic [3:0] starve_q, starve_d;

  wb_entry_t wr_q, wr_d;
  logic      wr_en_q, wr_en_d;

  logic contend;
  logic force_hold;
  logic hold_sel;

  // Arbitration: the ALU wins contention until the held load has lost STARVE_LIMIT times.
  always_comb begin
    contend    = alu_valid && hold_valid_q;
    force_hold = contend && (starve_q == 4'(STARVE_LIMIT));
    alu_ready  = alu_valid && !force_hold;
    hold_sel   = hold_valid_q && !alu_ready;
    ld_ready   = !hold_valid_q;
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    starve_d     = starve_q;

    if (hold_sel) begin
      hold_valid_d = 1'b0;
      starve_d     = '0;
    end else if (contend) begin
      starve_d = starve_q + 4'd1;
    end

    // ld_ready is low whenever hold_sel is high, so capture and drain never overlap.
    if (ld_valid && ld_ready) begin
      hold_valid_d = 1'b1;
      hold_d       = '{rd: ld_rd, data: ld_data, is_load: 1'b1};
    end
  end

  // Address/data only move on a real write; an x0 or idle cycle keeps the previous values.
  always_comb begin
    wr_d    = wr_q;
    wr_en_d = 1'b0;
    if (alu_ready) begin
      if (writes_reg(alu_rd)) begin
        wr_d    = '{rd: alu_rd, data: alu_data, is_load: 1'b0};
        wr_en_d = 1'b1;
      end
    end else if (hold_sel) begin
      if (writes_reg(hold_q.rd)) begin
        wr_d    = hold_q;
        wr_en_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      starve_q     <= '0;
      wr_q         <= '0;
      wr_en_q      <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      starve_q     <= starve_d;
      wr_q         <= wr_d;
      wr_en_q      <= wr_en_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_q.rd;
  assign wr_data = wr_q.data;

  // Clearing on the commit edge means decode never sees a cleared bit with stale data.
  wb_scoreboard #(
    .DEPTH    (REG_FILE_DEPTH),
    .ADDR_LEN (REG_FILE_ADDR_LEN)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .set_en       (ld_issue),
    .set_idx      (ld_issue_rd),
    .clr_en       (wr_en_q && wr_q.is_load),
    .clr_idx      (wr_q.rd),
    .pending      (pending),
    .protocol_err (protocol_err)
  );

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, ALU path, load path with scoreboard,
// starvation forcing, set/clear collision and protocol error.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_issue_rd = '0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pending;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  writeback_unit #(
    .XLEN              (32),
    .REG_FILE_DEPTH    (32),
    .REG_FILE_ADDR_LEN (5),
    .STARVE_LIMIT      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .ld_issue     (ld_issue),
    .ld_issue_rd  (ld_issue_rd),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pending      (pending),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset from power-up
    step();
    reset = 1'b1;
    #1;
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", wr_data, 32'd0);
    check_eq("rst_pending", pending, 32'd0);
    check_eq("rst_perr", 32'(protocol_err), 32'd0);
    check_eq("rst_ld_ready", 32'(ld_ready), 32'd1);
    check_eq("rst_alu_ready", 32'(alu_ready), 32'd0);

    // ALU only: rd=5, then rd=0
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    check_eq("alu_ready", 32'(alu_ready), 32'd1);
    step();
    alu_rd = 5'd0; alu_data = 32'h11111111;
    #1;
    check_eq("alu_wr_en", 32'(wr_en), 32'd1);
    check_eq("alu_wr_addr", 32'(wr_addr), 32'd5);
    check_eq("alu_wr_data", wr_data, 32'hDEADBEEF);
    check_eq("alu_x0_ready", 32'(alu_ready), 32'd1);
    step();
    alu_valid = 1'b0;
    #1;
    check_eq("alu_x0_wr_en", 32'(wr_en), 32'd0);
    check_eq("alu_x0_addr_held", 32'(wr_addr), 32'd5);
    check_eq("alu_x0_data_held", wr_data, 32'hDEADBEEF);

    // Load plus scoreboard on x7
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    step();
    ld_issue = 1'b0;
    #1;
    check_eq("ld_pend_set", pending, 32'h0000_0080);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h12345678;
    #1;
    check_eq("ld_ready_empty", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 1'b0;
    #1;
    check_eq("ld_not_direct", 32'(wr_en), 32'd0);
    check_eq("ld_ready_full", 32'(ld_ready), 32'd0);
    step();
    check_eq("ld_wr_en", 32'(wr_en), 32'd1);
    check_eq("ld_wr_addr", 32'(wr_addr), 32'd7);
    check_eq("ld_wr_data", wr_data, 32'h12345678);
    check_eq("ld_pend_held", pending, 32'h0000_0080);
    check_eq("ld_ready_drained", 32'(ld_ready), 32'd1);
    step();
    check_eq("ld_pend_clr", pending, 32'd0);
    check_eq("ld_wr_en_off", 32'(wr_en), 32'd0);

    // Starvation: held load to x4 against continuous ALU traffic to x10
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h0000_A5A5;
    step();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd10;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'd100 + 32'(i);
      #1;
      check_eq($sformatf("starve_alu_ready%0d", i), 32'(alu_ready), 32'd1);
      step();
      check_eq($sformatf("starve_alu_data%0d", i), wr_data, 32'd100 + 32'(i));
    end
    alu_data = 32'd200;
    #1;
    check_eq("starve_forced", 32'(alu_ready), 32'd0);
    step();
    check_eq("starve_ld_addr", 32'(wr_addr), 32'd4);
    check_eq("starve_ld_data", wr_data, 32'h0000_A5A5);
    check_eq("starve_ld_ready", 32'(ld_ready), 32'd1);
    check_eq("starve_alu_back", 32'(alu_ready), 32'd1);
    step();
    alu_valid = 1'b0;
    check_eq("starve_alu_after", wr_data, 32'd200);

    // Same-cycle set and clear of x9
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
    ld_issue = 1'b0;
    check_eq("col_pend_set", pending, 32'h0000_0200);
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    step();
    ld_valid = 1'b0;
    step();
    check_eq("col_wr_addr", 32'(wr_addr), 32'd9);
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
    ld_issue = 1'b0;
    check_eq("col_pend_kept", pending, 32'h0000_0200);
    check_eq("col_perr", 32'(protocol_err), 32'd0);

    // Protocol error on double issue to x3, then x0 issue ignored
    ld_issue = 1'b1; ld_issue_rd = 5'd3;
    step();
    check_eq("perr_first", 32'(protocol_err), 32'd0);
    check_eq("perr_pend", pending, 32'h0000_0208);
    step();
    ld_issue_rd = 5'd0;
    check_eq("perr_set", 32'(protocol_err), 32'd1);
    step();
    ld_issue = 1'b0;
    check_eq("perr_x0_pend", pending, 32'h0000_0208);
    step();
    check_eq("perr_sticky", 32'(protocol_err), 32'd1);

    // Reset mid-traffic: clean start, hold full, pending[5], protocol_err set
    reset = 1'b0;
    step();
    reset = 1'b1;
    ld_issue = 1'b1; ld_issue_rd = 5'd5;
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h55;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    step();
    ld_valid = 1'b0;
    step();
    ld_issue = 1'b0;
    check_eq("mid_pend", pending, 32'h0000_0020);
    check_eq("mid_perr", 32'(protocol_err), 32'd1);
    check_eq("mid_ld_ready", 32'(ld_ready), 32'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    alu_valid = 1'b0;
    #1;
    check_eq("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("mid_rst_pend", pending, 32'd0);
    check_eq("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
    check_eq("mid_rst_perr", 32'(protocol_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
